// File: rtl/reg_write_arbiter_if.sv
// Purpose : bundle of the requester-side handshake and register outputs of
//           reg_write_arbiter.
// Signals : req0/req1, d0/d1 (requests + write data, driven by requesters)
//           gnt0/gnt1, ld, ack0/ack1 (handshake, driven by the arbiter)
//           q (shared register), wcnt (completed-write counter)
// Modports: master = requester side, slave = arbiter side.
interface reg_write_arbiter_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 4
);
    logic          req0;
    logic          req1;
    logic [W-1:0]  d0;
    logic [W-1:0]  d1;
    logic          gnt0;
    logic          gnt1;
    logic          ld;
    logic          ack0;
    logic          ack1;
    logic [W-1:0]  q;
    logic [CW-1:0] wcnt;

    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, ld, ack0, ack1, q, wcnt
    );

    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, ld, ack0, ack1, q, wcnt
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Purpose : round-robin write arbiter owning a shared W-bit register.
//           Each write runs IDLE -> WR -> ACK; requests are only sampled in IDLE.
// Ports   : c     - clock, rising edge
//           rn    - asynchronous active-low reset
//           bus   - reg_write_arbiter_if.slave (requests, data, grants,
//                   load strobe, acks, register value, write counter)
module reg_write_arbiter #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 4
) (
    input  logic                 c,
    input  logic                 rn,
    reg_write_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          prio_q, prio_d;
    logic [W-1:0]  q_q, q_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          ld_q, ld_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;

    // State, datapath and output registers
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            q_q     <= '0;
            wcnt_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ld_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            q_q     <= q_d;
            wcnt_q  <= wcnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ld_q    <= ld_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    // Next-state logic and output decode
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        q_d     = q_q;
        wcnt_d  = wcnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Sole requester wins; on a tie the favoured side wins
                    sel_d   = (bus.req0 && bus.req1) ? prio_q : bus.req1;
                    state_d = WR;
                end
            end
            WR: begin
                q_d     = sel_q ? bus.d1 : bus.d0;
                wcnt_d  = wcnt_q + CW'(1);
                prio_d  = ~sel_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so the registered
        // versions line up with the state they describe
        gnt0_d = (state_d == WR)  && !sel_d;
        gnt1_d = (state_d == WR)  &&  sel_d;
        ld_d   = (state_d == WR);
        ack0_d = (state_d == ACK) && !sel_d;
        ack1_d = (state_d == ACK) &&  sel_d;
    end

    assign bus.gnt0 = gnt0_q;
    assign bus.gnt1 = gnt1_q;
    assign bus.ld   = ld_q;
    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign bus.q    = q_q;
    assign bus.wcnt = wcnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Purpose : directed self-checking bench for reg_write_arbiter. Expected
//           writes go into a scoreboard queue when driven and are popped by
//           an ack monitor.
module tb_reg_write_arbiter;

    typedef struct packed {
        logic       side;
        logic [3:0] data;
    } exp_t;

    logic c;
    logic rn;
    int   tests;
    int   fails;
    exp_t sb[$];
    logic [3:0] exp_wcnt;

    reg_write_arbiter_if #(.W(4), .CW(4)) bus ();

    reg_write_arbiter #(.W(4), .CW(4)) dut (
        .c   (c),
        .rn  (rn),
        .bus (bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 0);
        check({tag, "_gnt1"}, 32'(bus.gnt1), 0);
        check({tag, "_ld"},   32'(bus.ld),   0);
        check({tag, "_ack0"}, 32'(bus.ack0), 0);
        check({tag, "_ack1"}, 32'(bus.ack1), 0);
    endtask

    // One isolated write from a single requester; req dropped during ACK
    task automatic single_write(input logic side, input logic [3:0] data);
        if (side) begin bus.req1 = 1'b1; bus.d1 = data; end
        else      begin bus.req0 = 1'b1; bus.d0 = data; end
        sb.push_back('{side, data});
        tick();
        check("sw_gnt0", 32'(bus.gnt0), 32'(!side));
        check("sw_gnt1", 32'(bus.gnt1), 32'(side));
        check("sw_ld",   32'(bus.ld),   1);
        tick();
        exp_wcnt = exp_wcnt + 4'd1;
        check("sw_q",    32'(bus.q),    32'(data));
        check("sw_wcnt", 32'(bus.wcnt), 32'(exp_wcnt));
        check("sw_ackld", 32'(bus.ld),  0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        check_idle_outs("sw_idle");
        check("sw_qhold", 32'(bus.q), 32'(data));
    endtask

    // Async reset pulse starting mid-cycle; outputs must clear before any edge
    task automatic pulse_reset(input string tag);
        #2;
        rn = 1'b0;
        #1;
        check({tag, "_q"},    32'(bus.q),    0);
        check({tag, "_wcnt"}, 32'(bus.wcnt), 0);
        check_idle_outs(tag);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
        check({tag, "_hold_ack0"}, 32'(bus.ack0), 0);
        check({tag, "_hold_ack1"}, 32'(bus.ack1), 0);
        rn = 1'b1;
        exp_wcnt = 4'd0;
    endtask

    // Ack monitor: every ack must match the oldest expected write
    always @(negedge c) begin
        if (rn) begin
            check("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 0);
            check("ack_excl", 32'(bus.ack0 & bus.ack1), 0);
            if (bus.ack0 || bus.ack1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_ack: observed ack0=%0b ack1=%0b expected none", bus.ack0, bus.ack1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_side", 32'(bus.ack1), 32'(e.side));
                    check("ack_q",    32'(bus.q),    32'(e.data));
                end
            end
        end
    end

    initial begin
        int   grants;
        tests    = 0;
        fails    = 0;
        exp_wcnt = 4'd0;
        rn       = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.d0   = 4'd0;
        bus.d1   = 4'd0;

        // Power-on reset
        #12;
        check("rst_q",    32'(bus.q),    0);
        check("rst_wcnt", 32'(bus.wcnt), 0);
        check_idle_outs("rst");
        tick();
        rn = 1'b1;

        // Single writes, then async reset with q=1111
        single_write(1'b0, 4'b1010);
        single_write(1'b1, 4'b1111);
        check("pre_rst_q", 32'(bus.q), 32'hF);
        pulse_reset("arst");

        // Tie right after reset favours requester 0
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.d0 = 4'b0011; bus.d1 = 4'b1100;
        sb.push_back('{1'b0, 4'b0011});
        sb.push_back('{1'b1, 4'b1100});
        tick();
        check("tie_gnt0", 32'(bus.gnt0), 1);
        check("tie_gnt1", 32'(bus.gnt1), 0);
        tick();
        check("tie_q0", 32'(bus.q), 32'h3);
        bus.req0 = 1'b0;
        tick();
        check_idle_outs("tie_idle");
        tick();
        check("tie_gnt1b", 32'(bus.gnt1), 1);
        tick();
        check("tie_q1", 32'(bus.q), 32'hC);
        bus.req1 = 1'b0;
        tick();
        check("tie_wcnt", 32'(bus.wcnt), 2);
        exp_wcnt = 4'd2;

        // Fairness: both held 12 cycles -> grants 0,1,0,1
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back('{i[0], i[0] ? 4'b1100 : 4'b0011});
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.gnt0 || bus.gnt1) begin
                check("fair_side", 32'(bus.gnt1), 32'(grants[0]));
                grants++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("fair_cnt",  32'(grants),   4);
        check("fair_wcnt", 32'(bus.wcnt), 6);
        exp_wcnt = 4'd6;

        // Late request: req1 rises during req0's WR, req0 falls in WR
        bus.req0 = 1'b1; bus.d0 = 4'b0101;
        sb.push_back('{1'b0, 4'b0101});
        sb.push_back('{1'b1, 4'b1001});
        tick();
        check("late_gnt0", 32'(bus.gnt0), 1);
        bus.req1 = 1'b1; bus.d1 = 4'b1001;
        bus.req0 = 1'b0;
        tick();
        check("late_q0",   32'(bus.q),    32'h5);
        check("late_ack0", 32'(bus.ack0), 1);
        tick();
        check_idle_outs("late_idle");
        tick();
        check("late_gnt1", 32'(bus.gnt1), 1);
        tick();
        check("late_q1", 32'(bus.q), 32'h9);
        bus.req1 = 1'b0;
        tick();
        check("late_wcnt", 32'(bus.wcnt), 8);

        // Reset in WR abandons the write
        bus.req0 = 1'b1; bus.d0 = 4'b0110;
        tick();
        check("mwr_ld", 32'(bus.ld), 1);
        pulse_reset("mwr");

        // 16 writes with both requesting: starts at requester 0, wcnt wraps
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.d0 = 4'h7; bus.d1 = 4'h8;
        for (int i = 0; i < 16; i++) sb.push_back('{i[0], i[0] ? 4'h8 : 4'h7});
        grants = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (bus.gnt0 || bus.gnt1) begin
                check("wrap_side", 32'(bus.gnt1), 32'(grants[0]));
                grants++;
            end
            if (bus.ack0 || bus.ack1) begin
                exp_wcnt = exp_wcnt + 4'd1;
                check("wrap_wcnt", 32'(bus.wcnt), 32'(exp_wcnt));
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("wrap_cnt",   32'(grants),   16);
        check("wrap_zero",  32'(bus.wcnt), 0);

        tick();
        tick();
        check_idle_outs("end");
        check("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Owns a shared W-bit register built from rising-edge D flip-flops, with master-slave capture on the rising edge of c.
- Two requesters compete to write that register; this block sequences every write.
- Arbitration is round-robin. Each write uses a req/gnt/ack handshake and a fixed 3-state sequence.
- The register value and a write counter are available to downstream logic.

Parameters:
W, 4, width of the shared register and of each requester's data bus
CW, 4, width of the write counter wcnt

Ports:
c  in  1  clock; all state changes on rising edge
rn  in  1  reset, asynchronous, active-low
req0  in  1  write request from requester 0
req1  in  1  write request from requester 1
d0  in  W  write data from requester 0; held stable while req0=1
d1  in  W  write data from requester 1; held stable while req1=1
gnt0  out  1  requester 0 is being written this cycle
gnt1  out  1  requester 1 is being written this cycle
ld  out  1  load strobe; high exactly in WR
ack0  out  1  one-cycle write-complete pulse to requester 0
ack1  out  1  one-cycle write-complete pulse to requester 1
q  out  W  shared register contents
wcnt  out  CW  number of completed writes, modulo 2^CW

Behaviour:
- Clock and reset:
  - One clock c; reset is asynchronous and active-low (rn).
  - rn=0 forces immediately, without waiting for an edge: state=IDLE, q=0, wcnt=0, prio=0, sel=0, gnt0=gnt1=ld=ack0=ack1=0.
- Internal state:
  - state in {IDLE, WR, ACK}.
  - sel: 1 bit, the requester being served.
  - prio: 1 bit, the favoured requester on a tie.
- IDLE: all outputs low except q and wcnt.
  - At a rising edge, if req0|req1: sel <= winner, state <= WR. Otherwise stay in IDLE.
  - Winner: the sole requester. If both request, the winner is prio.
- WR: ld=1; gnt[sel]=1, other gnt=0.
  - At the rising edge: q <= d[sel], wcnt <= wcnt+1 (wraps 2^CW-1 -> 0), prio <= ~sel, state <= ACK.
- ACK: ack[sel]=1 for exactly this cycle; gnt and ld are low.
  - At the rising edge: state <= IDLE.
- Requests are sampled only in IDLE.
  - A req change during WR or ACK has no effect; a write that has started always completes.
  - A requester must drop req during its ACK cycle. If req is still high at the next IDLE edge, it is a new request.
- Latency: request seen at IDLE edge k -> gnt/ld high during cycle k..k+1 -> q updated at edge k+1 -> ack high during cycle k+1..k+2 -> IDLE after edge k+2.
  - Minimum 3 cycles per write; back-to-back writes every 3 cycles.
- Fairness: with both requests held continuously, grants strictly alternate.
- Outputs are decoded from registered state and sel only (Moore); no combinational path from req to gnt/ack.
- gnt0 and gnt1 are mutually exclusive; ack0 and ack1 are mutually exclusive.
- Reset mid-operation:
  - rn low in WR: the write is abandoned and q=0.
  - rn low in ACK: the ack pulse is cut short.
  - After rn rises, the first arbitration edge favours requester 0.

Test Plan:
- Reset: drive rn=0 in any state with q=1111 -> outputs zero at once, no clock needed: q=0000, wcnt=0, gnt0=gnt1=ld=ack0=ack1=0.
- Single write: req0=1, d0=1010 at edge 0 -> cycle 1: gnt0=ld=1; after edge 1: q=1010, wcnt=1; cycle 2: ack0=1; req0 dropped -> IDLE, q holds 1010.
- Tie after reset: req0=req1=1, d0=0011, d1=1100 -> first write to q=0011 with ack0; requester 0 drops req0; next write gnt1, q=1100, ack1; wcnt=2 after 6 cycles.
- Fairness: req0 and req1 held high for 12 cycles -> grant sequence 0,1,0,1; q alternates 0011/1100; never two consecutive gnt to the same side.
- Late request: req1 rises during requester 0's WR -> no effect until the next IDLE edge; q gets d0 then d1; req0 falling during WR still completes the write.
- Reset mid-WR plus wrap:
  - rn=0 while ld=1 -> q=0000 immediately, no ack.
  - Release rn, then 16 writes -> wcnt wraps 1111 -> 0000 on the 16th write.
